// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory bus between instruction fetch and data access,
// one transaction at a time, with a one-cycle ack, pipeline stall and a bus timeout.
//   state | meaning
//   IDLE  | no bus activity, grant decided here
//   BUSY  | transaction on the bus, waiting for bus_ready or timeout
//   DONE  | ack cycle for the owner, no bus activity
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ack,
    output logic        bus_en,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        stall,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nx;
    logic            owner_dm;
    logic            last_dm;
    logic [CW-1:0]   cnt;
    logic            grant_dm, grant_if;
    logic            finish, timed_out;
    logic [31:0]     cap;

    always_comb begin
        state_nx  = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        finish    = 1'b0;
        timed_out = 1'b0;
        cap       = 32'h0;
        case (state)
            IDLE: begin
                // data wins a tie unless it also won the previous grant
                grant_dm = dm_req & (~if_req | ~last_dm);
                grant_if = if_req & ~grant_dm;
                if (grant_dm | grant_if)
                    state_nx = BUSY;
            end
            BUSY: begin
                if (bus_ready) begin
                    finish   = 1'b1;
                    cap      = bus_we ? 32'h0 : bus_rdata;
                    state_nx = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    cap       = 32'hDEADBEEF;
                    state_nx  = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner_dm  <= 1'b0;
            last_dm   <= 1'b0;
            cnt       <= '0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            if_rdata  <= 32'h0;
            dm_rdata  <= 32'h0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state  <= state_nx;
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            if (grant_dm | grant_if) begin
                owner_dm  <= grant_dm;
                last_dm   <= grant_dm;
                bus_addr  <= (grant_dm ? dm_addr : if_addr) & 32'hFFFF_FFFC;
                bus_we    <= grant_dm & dm_we;
                bus_wdata <= grant_dm ? dm_wdata : 32'h0;
                cnt       <= '0;
            end else if (state == BUSY && !finish) begin
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                if (owner_dm) begin
                    dm_rdata <= cap;
                    dm_ack   <= 1'b1;
                end else begin
                    if_rdata <= cap;
                    if_ack   <= 1'b1;
                end
            end
            if (timed_out)
                bus_err <= 1'b1;
        end
    end

    assign bus_en = (state == BUSY);
    assign stall  = (if_req & ~if_ack) | (dm_req & ~dm_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios push expected bus and ack
// items; an independent monitor pops and compares whenever the DUT shows them.
module tb_mem_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [31:0] if_rdata, dm_rdata, bus_addr, bus_wdata;
    logic        if_ack, dm_ack, bus_en, bus_we, stall, bus_err;
    logic [31:0] bus_rdata = '0;
    logic        bus_ready = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready),
        .stall(stall), .bus_err(bus_err)
    );

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } bus_t;
    typedef struct { logic is_dm; logic [31:0] data; } ack_t;

    bus_t bus_q[$];
    ack_t ack_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wait_n = 0;
    bit   hang = 0;
    bit   mdl_last_dm = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h8C220004;
        return a ^ 32'h5A5A0F0F;
    endfunction

    task automatic exp_bus(input bit is_dm, input logic [31:0] a, input bit we, input logic [31:0] wd);
        bus_q.push_back('{a & 32'hFFFF_FFFC, is_dm & we, is_dm ? wd : 32'h0});
    endtask

    task automatic exp_ack(input bit is_dm, input logic [31:0] d);
        ack_q.push_back('{is_dm, d});
    endtask

    task automatic exp_txn(input bit is_dm, input logic [31:0] a, input bit we, input logic [31:0] wd);
        exp_bus(is_dm, a, we, wd);
        exp_ack(is_dm, (is_dm && we) ? 32'h0 : mem_fn(a & 32'hFFFF_FFFC));
    endtask

    // advance to the stimulus/sample point of the next cycle
    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    // bus device: ready after wait_n wait cycles, never when hang is set
    initial begin
        int beat;
        beat = 0;
        forever begin
            @(negedge clk);
            if (bus_en) begin
                bus_ready = !hang && (beat == wait_n);
                bus_rdata = mem_fn(bus_addr);
                beat++;
            end else begin
                bus_ready = 1'b0;
                bus_rdata = 32'h0;
                beat = 0;
            end
        end
    end

    initial begin
        logic pen, pack;
        bus_t cur;
        ack_t e;
        pen = 1'b0;
        pack = 1'b0;
        cur = '{32'h0, 1'b0, 32'h0};
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (bus_en && !pen) begin
                    if (bus_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bus_start: unexpected transaction at addr %h", bus_addr);
                    end else begin
                        cur = bus_q.pop_front();
                        chk("bus_addr", bus_addr, cur.addr);
                        chk("bus_we", bus_we, cur.we);
                        chk("bus_wdata", bus_wdata, cur.wdata);
                    end
                end else if (bus_en) begin
                    chk("bus_addr_hold", bus_addr, cur.addr);
                    chk("bus_we_hold", bus_we, cur.we);
                    chk("bus_wdata_hold", bus_wdata, cur.wdata);
                end
                if (if_ack || dm_ack) begin
                    chk("ack_exclusive", if_ack & dm_ack, 0);
                    chk("ack_one_cycle", pack, 0);
                    chk("bus_en_in_done", bus_en, 0);
                    if (ack_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ack_unexpected: if_ack %b dm_ack %b with none expected", if_ack, dm_ack);
                    end else begin
                        e = ack_q.pop_front();
                        chk("ack_owner_dm", dm_ack, e.is_dm);
                        chk("ack_rdata", dm_ack ? dm_rdata : if_rdata, e.data);
                    end
                end
            end
            pen = bus_en;
            pack = if_ack | dm_ack;
        end
    end

    task automatic hold_if();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            nx();
            if (if_ack) seen = 1;
        end
        if_req = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL if_ack_wait: no ack within 40 cycles, required one");
        end
    endtask

    task automatic hold_dm();
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            nx();
            if (dm_ack) seen = 1;
        end
        dm_req = 1'b0;
        dm_we = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL dm_ack_wait: no ack within 40 cycles, required one");
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bus_en"}, bus_en, 0);
        chk({tag, "_bus_we"}, bus_we, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_acks"}, {if_ack, dm_ack}, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_dm_rdata"}, dm_rdata, 0);
        chk({tag, "_bus_err"}, bus_err, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    initial begin
        repeat (3) nx();
        rst = 1'b0;
        check_zero("reset");

        // store, 3 wait states
        wait_n = 3;
        dm_req = 1; dm_we = 1; dm_addr = 32'h10000004; dm_wdata = 32'h55AA;
        exp_txn(1, 32'h10000004, 1, 32'h55AA);
        for (int n = 1; n <= 5; n++) begin
            nx();
            if (n <= 4) begin
                chk("st_bus_en", bus_en, 1);
                chk("st_dm_ack_early", dm_ack, 0);
            end else begin
                chk("st_dm_ack", dm_ack, 1);
                chk("st_dm_rdata", dm_rdata, 0);
            end
        end
        dm_req = 0; dm_we = 0;
        nx();
        chk("st_idle_bus_en", bus_en, 0);

        // single fetch, zero wait
        wait_n = 0;
        if_req = 1; if_addr = 32'h103;
        exp_txn(0, 32'h100, 0, 0);
        #1 chk("f_stall_c0", stall, 1);
        chk("f_bus_en_c0", bus_en, 0);
        nx();
        chk("f_bus_en_c1", bus_en, 1);
        chk("f_bus_addr_c1", bus_addr, 32'h100);
        chk("f_stall_c1", stall, 1);
        nx();
        chk("f_if_ack_c2", if_ack, 1);
        chk("f_if_rdata_c2", if_rdata, 32'h8C220004);
        chk("f_stall_c2", stall, 0);
        if_req = 0;
        nx();
        chk("f_bus_en_c3", bus_en, 0);
        chk("f_if_ack_c3", if_ack, 0);

        // simultaneous requests, both held, zero wait
        exp_txn(1, 32'h2040, 0, 32'h77);
        exp_txn(0, 32'h3080, 0, 0);
        exp_txn(1, 32'h2040, 0, 32'h77);
        dm_req = 1; dm_we = 0; dm_addr = 32'h2040; dm_wdata = 32'h77;
        if_req = 1; if_addr = 32'h3080;
        for (int n = 1; n <= 8; n++) begin
            nx();
            chk($sformatf("both_dm_ack_c%0d", n), dm_ack, (n == 2 || n == 8) ? 1 : 0);
            chk($sformatf("both_if_ack_c%0d", n), if_ack, (n == 5) ? 1 : 0);
            if (n == 5) if_req = 0;
            if (n == 8) dm_req = 0;
        end
        nx();

        // timeout with bus_ready held low
        hang = 1;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_wdata = 0;
        exp_bus(1, 32'h2000, 0, 0);
        exp_ack(1, 32'hDEADBEEF);
        for (int n = 1; n <= 5; n++) begin
            nx();
            if (n <= 4) begin
                chk("to_bus_en", bus_en, 1);
                chk("to_bus_err_early", bus_err, 0);
            end else begin
                chk("to_dm_ack", dm_ack, 1);
                chk("to_dm_rdata", dm_rdata, 32'hDEADBEEF);
                chk("to_bus_err", bus_err, 1);
                chk("to_bus_en_done", bus_en, 0);
            end
        end
        dm_req = 0;
        repeat (20) nx();
        chk("to_bus_err_sticky", bus_err, 1);
        hang = 0;

        // reset in the second wait cycle of a store
        hang = 1;
        dm_req = 1; dm_we = 1; dm_addr = 32'h3008; dm_wdata = 32'h1234;
        exp_bus(1, 32'h3008, 1, 32'h1234);
        nx();
        chk("rb_bus_en", bus_en, 1);
        chk("rb_bus_we", bus_we, 1);
        nx();
        rst = 1; dm_req = 0; dm_we = 0;
        nx();
        rst = 0;
        check_zero("rb");
        hang = 0;
        repeat (8) nx();
        wait_n = 1;
        if_req = 1; if_addr = 32'h44;
        exp_txn(0, 32'h44, 0, 0);
        hold_if();
        nx();
        mdl_last_dm = 0;

        // random mix of single and contending requests
        for (int t = 0; t < 12; t++) begin
            int sel;
            logic [31:0] ia, da, wd;
            bit we;
            sel = $urandom_range(1, 3);
            wait_n = $urandom_range(0, 3);
            ia = $urandom; da = $urandom; wd = $urandom; we = 1'($urandom_range(0, 1));
            if (sel == 1) begin
                exp_txn(0, ia, 0, 0);
                mdl_last_dm = 0;
            end else if (sel == 2) begin
                exp_txn(1, da, we, wd);
                mdl_last_dm = 1;
            end else if (mdl_last_dm) begin
                exp_txn(0, ia, 0, 0);
                exp_txn(1, da, we, wd);
                mdl_last_dm = 1;
            end else begin
                exp_txn(1, da, we, wd);
                exp_txn(0, ia, 0, 0);
                mdl_last_dm = 0;
            end
            if (sel != 2) begin if_req = 1; if_addr = ia; end
            if (sel != 1) begin dm_req = 1; dm_we = we; dm_addr = da; dm_wdata = wd; end
            fork
                if (sel != 2) hold_if();
                if (sel != 1) hold_dm();
            join
            nx();
        end
        repeat (3) nx();
        chk("bus_q_drained", bus_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
